// File: rtl/chu_vga_sprite_anim_core.sv
// chu_vga_sprite_anim_core: overlays one animated 32x32 sprite on the pixel stream with a fixed 2-clk latency
module chu_vga_sprite_anim_core #(
    parameter int CD = 12,
    parameter int ADDR_WIDTH = 12,
    parameter logic [CD-1:0] KEY_COLOR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          frame_start,
    input  logic          cs,
    input  logic          write,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);
    logic [CD-1:0] ram [0:2**ADDR_WIDTH-1];
    logic [CD-1:0] ram_q, si_rgb_d1;
    logic [10:0] x0, y0, xr, yr;
    logic [7:0] period, tick_cnt;
    logic [1:0] last, sel, frame_idx;
    logic enable, anim_en, hit, hit_d1, ram_we, reg_we, tick_clr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic unused_bits;

    assign ram_we = cs && write && !addr[13];
    assign reg_we = cs && write && addr[13];
    assign tick_clr = reg_we && (addr[2:0] == 3'd3 || addr[2:0] == 3'd4);
    assign xr = x - x0;
    assign yr = y - y0;
    // 12-bit upper bounds keep a sprite parked near column/row 2047 from wrapping to 0
    assign hit = (x >= x0) && ({1'b0, x} < {1'b0, x0} + 12'd32) &&
                 (y >= y0) && ({1'b0, y} < {1'b0, y0} + 12'd32);
    assign rd_addr = ADDR_WIDTH'({frame_idx, yr[4:0], xr[4:0]});
    assign unused_bits = ^{wr_data, addr, xr[10:5], yr[10:5]};

    // sprite RAM, read-first synchronous port (cycle 0 -> ram_q in cycle 1)
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[addr[ADDR_WIDTH-1:0]] <= wr_data[CD-1:0];
        ram_q <= ram[rd_addr];
    end

    // two-stage pixel pipeline: align upstream pixel with RAM output, then mux
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            si_rgb_d1 <= '0;
            hit_d1 <= 1'b0;
            so_rgb <= '0;
        end else begin
            si_rgb_d1 <= si_rgb;
            hit_d1 <= hit && enable;
            so_rgb <= (hit_d1 && ram_q != KEY_COLOR) ? ram_q : si_rgb_d1;
        end
    end

    // control register writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0 <= '0;
            y0 <= '0;
            enable <= 1'b0;
            anim_en <= 1'b0;
            period <= '0;
            last <= '0;
            sel <= '0;
        end else if (reg_we) begin
            case (addr[2:0])
                3'd0: x0 <= wr_data[10:0];
                3'd1: y0 <= wr_data[10:0];
                3'd2: {anim_en, enable} <= wr_data[1:0];
                3'd3: period <= wr_data[7:0];
                3'd4: last <= wr_data[1:0];
                3'd5: sel <= wr_data[1:0];
                default: ;
            endcase
        end
    end

    // frame selection, only changes on frame_start so the sprite never tears; period/last writes restart the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_idx <= '0;
            tick_cnt <= '0;
        end else begin
            if (frame_start) begin
                if (!anim_en) begin
                    frame_idx <= sel;
                    tick_cnt <= '0;
                end else if (tick_cnt == period) begin
                    tick_cnt <= '0;
                    frame_idx <= (frame_idx >= last) ? 2'd0 : frame_idx + 2'd1;
                end else begin
                    tick_cnt <= tick_cnt + 8'd1;
                end
            end
            if (tick_clr)
                tick_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_chu_vga_sprite_anim_core.sv
// tb_chu_vga_sprite_anim_core: directed and randomized checks of the sprite overlay against a pixel-level model
module tb_chu_vga_sprite_anim_core;
    logic clk = 1'b0, rst = 1'b1;
    logic [10:0] x = '0, y = '0;
    logic frame_start = 1'b0, cs = 1'b0, write = 1'b0;
    logic [13:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [11:0] si_rgb = '0, so_rgb;

    chu_vga_sprite_anim_core dut (
        .clk(clk), .reset(rst), .x(x), .y(y), .frame_start(frame_start),
        .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
        .si_rgb(si_rgb), .so_rgb(so_rgb)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [11:0] mem [4096];
    int m_x0, m_y0, m_en, m_anim, m_per, m_last, m_sel, m_frame, m_cnt;

    task automatic model_reset();
        m_x0 = 0; m_y0 = 0; m_en = 0; m_anim = 0; m_per = 0;
        m_last = 0; m_sel = 0; m_frame = 0; m_cnt = 0;
    endtask

    // displayed frame steps once every (period+1) frame starts, counted since the last step or restart
    task automatic model_fs();
        if (m_anim == 0) begin
            m_frame = m_sel;
            m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt > m_per) begin
                m_cnt = 0;
                m_frame = (m_frame >= m_last) ? 0 : m_frame + 1;
            end
        end
    endtask

    task automatic model_wr(input logic [13:0] a, input logic [31:0] d);
        if (!a[13]) mem[a[11:0]] = d[11:0];
        else case (a[2:0])
            3'd0: m_x0 = int'(d[10:0]);
            3'd1: m_y0 = int'(d[10:0]);
            3'd2: begin m_en = int'(d[0]); m_anim = int'(d[1]); end
            3'd3: begin m_per = int'(d[7:0]); m_cnt = 0; end
            3'd4: begin m_last = int'(d[1:0]); m_cnt = 0; end
            3'd5: m_sel = int'(d[1:0]);
            default: ;
        endcase
    endtask

    function automatic logic [11:0] exp_px(int xx, int yy, logic [11:0] s);
        int dx, dy;
        logic [11:0] p;
        dx = xx - m_x0;
        dy = yy - m_y0;
        if (m_en == 0 || dx < 0 || dx > 31 || dy < 0 || dy > 31) return s;
        p = mem[m_frame * 1024 + dy * 32 + dx];
        return (p == 12'h000) ? s : p;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk);
        #1 cs = 1'b0; write = 1'b0;
        model_wr(a, d);
    endtask

    task automatic fs();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        model_fs();
    endtask

    task automatic wr_fs(input logic [13:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d; frame_start = 1'b1;
        @(posedge clk);
        #1 cs = 1'b0; write = 1'b0; frame_start = 1'b0;
        model_fs();
        model_wr(a, d);
    endtask

    task automatic reg_wr(input int r, input int v);
        wr(14'h2000 | 14'(r), 32'(v));
    endtask

    task automatic fill(input int f, input logic [11:0] c);
        for (int i = 0; i < 1024; i++) wr(14'(f * 1024 + i), 32'(c));
    endtask

    // pixel presented for one cycle, followed by a different off-sprite pixel: result must appear exactly 2 clk later
    task automatic px(input int xx, input int yy, input logic [11:0] s, input string tag);
        logic [11:0] e;
        e = exp_px(xx, yy, s);
        @(negedge clk);
        x = 11'(xx); y = 11'(yy); si_rgb = s;
        @(negedge clk);
        y = 11'((m_y0 + 40) % 2048); si_rgb = ~s;
        @(posedge clk);
        #1 chk(tag, so_rgb, e);
    endtask

    initial begin
        model_reset();
        #12 chk("reset_so_rgb", so_rgb, 12'h000);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 4; i++) px(10 * i, i, 12'h00F, "passthrough");

        fill(0, 12'hF00);
        wr(14'(5 * 32 + 3), 32'h0);
        reg_wr(0, 100); reg_wr(1, 50); reg_wr(2, 1);
        px(100, 50, 12'h0A5, "ovl_origin");
        px(103, 55, 12'h0A5, "ovl_key");
        px(131, 81, 12'h0A5, "ovl_corner");
        px(132, 50, 12'h0A5, "ovl_right_out");
        px(99, 50, 12'h0A5, "ovl_left_out");
        px(100, 82, 12'h0A5, "ovl_below_out");

        reg_wr(0, 2040); reg_wr(1, 0);
        for (int i = 0; i < 16; i++) px((2040 + i) % 2048, 1, 12'h07E, "clip_wrap");

        for (int f = 0; f < 4; f++) fill(f, 12'(f + 1));
        reg_wr(0, 100); reg_wr(1, 50); reg_wr(5, 0); reg_wr(2, 1);
        fs();
        reg_wr(4, 3); reg_wr(3, 2); reg_wr(2, 3);
        for (int k = 0; k < 13; k++) begin
            px(100 + k, 50 + k, 12'($urandom), "anim_seq");
            fs();
        end
        wr_fs(14'h2003, 32'd2);
        fs(); fs();
        px(110, 60, 12'h123, "anim_clear_wins");
        fs();
        px(110, 60, 12'h123, "anim_after_clear");

        reg_wr(2, 1); reg_wr(5, 2);
        fs();
        px(105, 52, 12'h321, "manual_sel");
        reg_wr(5, 3);
        fs();
        reg_wr(3, 0); reg_wr(4, 1); reg_wr(2, 3);
        fs();
        px(105, 52, 12'h321, "shrink_wrap");
        fs();
        px(105, 52, 12'h321, "shrink_next");
        fs();
        px(105, 52, 12'h321, "shrink_wrap2");

        for (int i = 0; i < 1024; i++)
            wr(14'(i), ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom_range(1, 4095)));
        reg_wr(2, 1); reg_wr(5, 0);
        fs();
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) begin
                reg_wr(0, int'($urandom_range(0, 2047)));
                reg_wr(1, int'($urandom_range(0, 2047)));
            end
            px((m_x0 + int'($urandom_range(0, 47)) - 8 + 2048) % 2048,
               (m_y0 + int'($urandom_range(0, 47)) - 8 + 2048) % 2048,
               12'($urandom), "random_px");
        end

        for (int f = 1; f < 4; f++) fill(f, 12'(f + 1));
        reg_wr(0, 100); reg_wr(1, 50); reg_wr(2, 1); reg_wr(5, 2);
        fs();
        reg_wr(3, 5); reg_wr(2, 3);
        px(100, 50, 12'h0AB, "pre_reset");
        @(negedge clk);
        x = 11'd100; y = 11'd50; si_rgb = 12'h0AB;
        repeat (3) @(negedge clk);
        chk("so_rgb_before_reset", so_rgb, 12'h003);
        #1 rst = 1'b1;
        #1 chk("async_reset_so_rgb", so_rgb, 12'h000);
        chk("async_reset_frame_idx", 12'(dut.frame_idx), 12'h000);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        px(100, 50, 12'h0AB, "post_reset_passthrough");
        reg_wr(0, 100); reg_wr(1, 50); reg_wr(2, 1); reg_wr(5, 2);
        fs();
        px(100, 50, 12'h0AB, "ram_intact_f2");
        reg_wr(5, 1);
        fs();
        px(120, 70, 12'h0AB, "ram_intact_f1");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/chu_vga_sprite_anim_core.md
Name: chu_vga_sprite_anim_core

Overview:
- Daisy-chain video slot core that overlays one animated 32x32 sprite onto the pixel stream.
- Occupies the ghost slot (V3): takes si_rgb from the user4 stage and drives so_rgb into the OSD/mouse stages. Its total latency matches every other slot, so the 2-stage start/inc delay line stays valid.
- Holds up to 4 animation frames in on-chip sprite RAM.
- Advances the displayed frame on a programmable frame-count period; the update happens only at frame start, so the sprite never tears.

Parameters:
- CD, 12, colour depth of si_rgb/so_rgb and of each sprite pixel.
- ADDR_WIDTH, 12, sprite RAM address width (4 frames x 32 x 32 = 4096 pixels).
- KEY_COLOR, 0, sprite pixel value treated as transparent.

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  asynchronous, active-high reset.
- x  in  11  current pixel column from frame_counter.
- y  in  11  current pixel row from frame_counter.
- frame_start  in  1  one-cycle pulse at pixel (0,0), undelayed.
- cs  in  1  slot chip select.
- write  in  1  slot write strobe.
- addr  in  14  slot word address.
- wr_data  in  32  slot write data.
- si_rgb  in  CD  upstream pixel.
- so_rgb  out  CD  downstream pixel.

Behaviour:
- Clocking/reset: one clock, clk. Reset is asynchronous and active-high; every register clears on reset. Sprite RAM contents are not reset.
- Reset values: so_rgb=0, x0=0, y0=0, enable=0, anim_en=0, period=0, last=0, sel=0, frame_idx=0, tick_cnt=0.
- Bus decode (write only; no read path). A write occurs when cs && write:
  - addr[13]=0: sprite RAM write. RAM[addr[11:0]] <= wr_data[CD-1:0].
  - addr[13]=1, addr[2:0]:
    - 0: x0 <= wr_data[10:0].
    - 1: y0 <= wr_data[10:0].
    - 2: ctrl; enable <= wr_data[0], anim_en <= wr_data[1].
    - 3: period <= wr_data[7:0].
    - 4: last <= wr_data[1:0] (number of frames minus 1).
    - 5: sel <= wr_data[1:0] (manual frame select).
    - 6, 7: ignored.
  - Writes to registers 3 or 4 also clear tick_cnt.
- Hit test (cycle 0, combinational):
  - xr = x - x0, yr = y - y0.
  - hit = (x >= x0) && ({1'b0,x} < {1'b0,x0}+32) && (y >= y0) && ({1'b0,y} < {1'b0,y0}+32).
  - The 12-bit compare is required so a sprite near 2047 does not wrap.
  - Sprite extending past 639/479 is simply clipped.
- Pipeline, fixed latency exactly 2 clk:
  - Cycle 0: RAM read address = {frame_idx, yr[4:0], xr[4:0]}; synchronous RAM read.
  - Cycle 1: si_rgb_d1 <= si_rgb; hit_d1 <= hit && enable.
  - Cycle 2: so_rgb <= (hit_d1 && ram_q != KEY_COLOR) ? ram_q : si_rgb_d1.
  - The pipeline advances every clk regardless of inc; the delay line elsewhere handles alignment.
- Animation (registers updated only on frame_start):
  - anim_en=0: frame_idx <= sel at each frame_start; tick_cnt holds 0.
  - anim_en=1, tick_cnt < period: tick_cnt++.
  - anim_en=1, tick_cnt == period: tick_cnt <= 0; frame_idx <= (frame_idx >= last) ? 0 : frame_idx+1.
  - Net effect: the frame advances every (period+1) frames. period=0 advances every frame.
  - last=0 pins frame 0.
  - Writing last below the current frame_idx: the next advance wraps to 0.
- Simultaneous events:
  - A register write and frame_start in the same cycle: frame_start logic uses the old register values; the new values apply from the next cycle.
  - A write of reg 3/4 coinciding with frame_start: the clear of tick_cnt wins.
- Reset mid-frame: so_rgb is forced to 0 immediately; after release, pixels pass through (enable=0) within 2 clk.
- Sprite RAM write during active display: allowed. A same-cycle read of the same address returns old data (read-first).

Test Plan:
- Pass-through: after reset, enable=0, si_rgb=12'h00F for all pixels -> so_rgb=12'h00F exactly 2 clk after each input; reset value of so_rgb is 0.
- Overlay/transparency: frame 0 filled with 12'hF00 except pixel (3,5)=0; x0=100, y0=50, enable=1.
  - (x,y)=(100,50) -> 12'hF00.
  - (103,55) -> si_rgb.
  - (131,81) -> F00.
  - (132,50) -> si_rgb.
- Clipping/wrap: x0=2040, y0=0 -> hit only for x in 2040..2047; x=0..7 shows si_rgb (no wrap).
- Animation: frames 0..3 filled with distinct colours 1,2,3,4; last=3, period=2, anim_en=1; pulse frame_start 12 times -> displayed colour sequence 1,1,1,2,2,2,3,3,3,4,4,4, then wraps to 1.
- Manual select and shrink: anim_en=0, sel=2 -> colour 3 after the next frame_start. Then anim_en=1, frame_idx=3, write last=1 -> the next advance shows frame 0.
- Async reset mid-animation with frame_idx=2 -> frame_idx=0 and so_rgb=0 without a clock edge; sprite RAM contents intact after release.
